// File: rtl/if_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_ctrl_pkg
// Description : Shared pipeline definitions for the instruction-fetch stage:
//               fetch state encoding, reset PC, sequential increment and the
//               NOP encoding used when the IF/ID register is cleared.
// Revision    : 1.0 - initial release
// ============================================================================
package if_fetch_ctrl_pkg;

    // Fetch controller states.
    // IDLE  : one-cycle start-up after reset, no request.
    // FETCH : request outstanding at the current PC.
    // HOLD  : fetched word parked while the hazard unit stalls, no request.
    // DRAIN : request to a stale address outstanding; its response is dropped.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_t;

    // Architectural PC after reset (word aligned).
    localparam logic [31:0] c_reset_pc = 32'h0000_0000;

    // Sequential PC increment in bytes.
    localparam logic [31:0] c_inc = 32'd4;

    // Instruction word loaded into IF/ID on reset.
    localparam logic [31:0] c_nop = 32'h0000_0000;

    // Force an address onto a word boundary by clearing bits [1:0].
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage : if_fetch_ctrl_pkg
`default_nettype wire

// File: rtl/if_fetch_ctrl_ifid.sv
`default_nettype none
// ============================================================================
// Module      : ifid_reg
// Description : IF/ID pipeline register. Load captures a new instruction and
//               marks it valid, flush turns the slot into a bubble, otherwise
//               the contents are held. Flush wins over load.
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_reg
    import if_fetch_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic [31:0] d_pc,
    input  logic [31:0] d_pc4,
    input  logic [31:0] d_instr,
    output logic        valid,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] instr
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_pc4;
    logic [31:0] r_instr;

    // Pipeline slot update: a flush only clears the valid bit so the data
    // fields keep their last value and never toggle needlessly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pc    <= 32'h0000_0000;
            r_pc4   <= 32'h0000_0000;
            r_instr <= c_nop;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_pc    <= d_pc;
            r_pc4   <= d_pc4;
            r_instr <= d_instr;
        end
    end

    assign valid = r_valid;
    assign pc    = r_pc;
    assign pc4   = r_pc4;
    assign instr = r_instr;

endmodule : ifid_reg
`default_nettype wire

// File: rtl/if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_ctrl
// Description : Instruction-fetch controller. Owns the PC, issues one word
//               request at a time to instruction memory over req/ack, parks
//               a fetched word while the hazard unit stalls, and drops the
//               response of a request made stale by an EX redirect.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_reset_pc,
    parameter logic [31:0] INC      = c_inc
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic        ifid_valid,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic [31:0] ifid_instr
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_drain_addr;
    logic [31:0]  r_hold_pc;
    logic [31:0]  r_hold_instr;

    logic [31:0]  w_pc_inc;
    logic [31:0]  w_target;
    logic         w_ifid_load;
    logic         w_ifid_flush;
    logic [31:0]  w_ifid_pc;
    logic [31:0]  w_ifid_instr;

    // Shared PC adder; wraps modulo 2^32.
    assign w_pc_inc = r_pc + INC;
    assign w_target = word_align(redirect_pc);

    // Memory interface decoded from state. In DRAIN the stale address stays
    // on the bus until its response arrives so the memory sees a stable
    // request.
    assign imem_req  = (r_state == S_FETCH) || (r_state == S_DRAIN);
    assign imem_addr = (r_state == S_DRAIN) ? r_drain_addr : r_pc;
    assign pc        = r_pc;

    // IF/ID load/flush selection. The held word always belongs to the
    // current PC (the PC does not advance when a word is parked), so the
    // single PC adder also provides pc+INC for the parked word.
    always_comb begin
        w_ifid_load  = 1'b0;
        w_ifid_flush = 1'b0;
        w_ifid_pc    = r_pc;
        w_ifid_instr = imem_rdata;
        case (r_state)
            S_FETCH: begin
                if (redirect) begin
                    w_ifid_flush = 1'b1;
                end else if (imem_ack && !stall) begin
                    w_ifid_load = 1'b1;
                end else if (!imem_ack && !stall) begin
                    w_ifid_flush = 1'b1;
                end
            end
            S_HOLD: begin
                w_ifid_pc    = r_hold_pc;
                w_ifid_instr = r_hold_instr;
                if (redirect) begin
                    w_ifid_flush = 1'b1;
                end else if (!stall) begin
                    w_ifid_load = 1'b1;
                end
            end
            S_DRAIN: begin
                w_ifid_flush = 1'b1;
            end
            default: begin
                w_ifid_load  = 1'b0;
                w_ifid_flush = 1'b0;
            end
        endcase
    end

    // Fetch state machine: PC, stale-address latch and stall hold buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_PC;
            r_drain_addr <= 32'h0000_0000;
            r_hold_pc    <= 32'h0000_0000;
            r_hold_instr <= c_nop;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (redirect) begin
                        r_pc <= w_target;
                        // Without an ack this cycle the old request is still
                        // in flight and must be absorbed before refetching.
                        if (!imem_ack) begin
                            r_drain_addr <= r_pc;
                            r_state      <= S_DRAIN;
                        end
                    end else if (imem_ack) begin
                        if (!stall) begin
                            r_pc <= w_pc_inc;
                        end else begin
                            r_hold_pc    <= r_pc;
                            r_hold_instr <= imem_rdata;
                            r_state      <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        r_pc    <= w_target;
                        r_state <= S_FETCH;
                    end else if (!stall) begin
                        r_pc    <= w_pc_inc;
                        r_state <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    // A further redirect only retargets the PC; the stale
                    // response is still the one being waited for, and its
                    // arrival ends the drain regardless.
                    if (redirect) begin
                        r_pc <= w_target;
                    end
                    if (imem_ack) begin
                        r_state <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    ifid_reg u_ifid_reg (
        .clk     (clk),
        .rst     (rst),
        .load    (w_ifid_load),
        .flush   (w_ifid_flush),
        .d_pc    (w_ifid_pc),
        .d_pc4   (w_pc_inc),
        .d_instr (w_ifid_instr),
        .valid   (ifid_valid),
        .pc      (ifid_pc),
        .pc4     (ifid_pc4),
        .instr   (ifid_instr)
    );

endmodule : if_fetch_ctrl
`default_nettype wire

// File: tb/tb_if_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_ctrl
// Description : Self-checking bench for if_fetch_ctrl. A behavioural model of
//               the fetch stage tracks expected outputs every cycle; directed
//               sequences pin literal values, then randomized traffic runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_ctrl;

    localparam logic [31:0] c_key = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] pc;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;

    int n_checks = 0;
    int n_fail   = 0;
    logic cmp_en = 1'b0;

    // memory responder controls
    logic mem_always = 1'b1;
    logic mem_off    = 1'b0;
    int   lat_set    = 0;
    int   lat_cnt    = 0;

    always #5 clk = ~clk;

    if_fetch_ctrl #(
        .RESET_PC (32'h0000_0000),
        .INC      (32'd4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .ifid_valid  (ifid_valid),
        .ifid_pc     (ifid_pc),
        .ifid_pc4    (ifid_pc4),
        .ifid_instr  (ifid_instr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: "started", a parked word, a request whose answer
    // is to be thrown away, and the instruction presented to decode.
    // ------------------------------------------------------------------
    logic        m_started = 1'b0;
    logic [31:0] m_pc = 32'h0;
    logic        m_buf_full = 1'b0;
    logic [31:0] m_buf_pc = 32'h0;
    logic [31:0] m_buf_instr = 32'h0;
    logic        m_discard = 1'b0;
    logic [31:0] m_old_addr = 32'h0;
    logic        m_valid = 1'b0;
    logic [31:0] m_ipc = 32'h0;
    logic [31:0] m_ipc4 = 32'h0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_tgt;
    logic        m_req;
    logic [31:0] m_addr;

    assign m_tgt  = redirect_pc & ~32'h3;
    assign m_req  = m_started && !m_buf_full;
    assign m_addr = m_discard ? m_old_addr : m_pc;

    always @(posedge clk) begin
        if (rst) begin
            m_started  <= 1'b0;
            m_pc       <= 32'h0;
            m_buf_full <= 1'b0;
            m_discard  <= 1'b0;
            m_old_addr <= 32'h0;
            m_valid    <= 1'b0;
            m_ipc      <= 32'h0;
            m_ipc4     <= 32'h0;
            m_instr    <= 32'h0;
        end else if (!m_started) begin
            m_started <= 1'b1;
        end else if (m_discard) begin
            if (redirect) m_pc <= m_tgt;
            if (imem_ack) m_discard <= 1'b0;
        end else if (m_buf_full) begin
            if (redirect) begin
                m_buf_full <= 1'b0;
                m_pc       <= m_tgt;
                m_valid    <= 1'b0;
            end else if (!stall) begin
                m_valid    <= 1'b1;
                m_ipc      <= m_buf_pc;
                m_ipc4     <= m_buf_pc + 32'd4;
                m_instr    <= m_buf_instr;
                m_pc       <= m_buf_pc + 32'd4;
                m_buf_full <= 1'b0;
            end
        end else begin
            if (redirect) begin
                m_valid <= 1'b0;
                m_pc    <= m_tgt;
                if (!imem_ack) begin
                    m_discard  <= 1'b1;
                    m_old_addr <= m_pc;
                end
            end else if (imem_ack && !stall) begin
                m_valid <= 1'b1;
                m_ipc   <= m_pc;
                m_ipc4  <= m_pc + 32'd4;
                m_instr <= imem_rdata;
                m_pc    <= m_pc + 32'd4;
            end else if (imem_ack) begin
                m_buf_full  <= 1'b1;
                m_buf_pc    <= m_pc;
                m_buf_instr <= imem_rdata;
            end else if (!stall) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("req", {31'b0, imem_req}, {31'b0, m_req});
            if (m_req) chk("addr", imem_addr, m_addr);
            chk("pc", pc, m_pc);
            chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
            if (m_valid) begin
                chk("ifid_pc", ifid_pc, m_ipc);
                chk("ifid_pc4", ifid_pc4, m_ipc4);
                chk("ifid_instr", ifid_instr, m_instr);
            end
        end
    end

    // Advance to the next falling edge and drive the memory response.
    task automatic cyc();
        @(negedge clk);
        if (mem_always) begin
            imem_ack   = 1'b1;
            imem_rdata = imem_addr ^ c_key;
        end else if (mem_off) begin
            imem_ack = 1'b0;
        end else begin
            imem_ack = 1'b0;
            if (imem_req) begin
                if (lat_cnt <= 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = imem_addr ^ c_key;
                    lat_cnt    = (lat_set < 0) ? int'($urandom_range(0, 3)) : lat_set;
                end else begin
                    lat_cnt--;
                end
            end
        end
    endtask

    initial begin
        int vcount;
        // ---------------- reset and single-cycle memory ----------------
        cyc(); cyc();
        cmp_en = 1'b1;
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
        chk("rst_ifid_pc", ifid_pc, 32'h0);
        chk("rst_ifid_pc4", ifid_pc4, 32'h0);
        chk("rst_ifid_instr", ifid_instr, 32'h0);
        rst = 1'b0;
        cyc();
        chk("first_req", {31'b0, imem_req}, 32'h1);
        chk("first_addr", imem_addr, 32'h0);
        chk("first_valid", {31'b0, ifid_valid}, 32'h0);
        cyc();
        chk("d0_valid", {31'b0, ifid_valid}, 32'h1);
        chk("d0_pc", ifid_pc, 32'h0);
        chk("d0_pc4", ifid_pc4, 32'h4);
        chk("d0_instr", ifid_instr, 32'hA5A5_0000);
        cyc();
        chk("d1_pc", ifid_pc, 32'h4);
        cyc();
        chk("d2_pc", ifid_pc, 32'h8);
        chk("d2_fetch_pc", pc, 32'hC);

        // ---------------- three-cycle memory latency ----------------
        mem_always = 1'b0;
        lat_set = 2;
        lat_cnt = 2;
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (ifid_valid) vcount++;
        end
        chk("lat3_valid_count", vcount, 32'd4);

        // ---------------- stall with ack inside the stall ----------------
        lat_set = 0;
        lat_cnt = 0;
        cyc();
        redirect = 1'b1; redirect_pc = 32'h10;
        cyc();
        redirect = 1'b0; stall = 1'b1;
        cyc();
        chk("hold_req", {31'b0, imem_req}, 32'h0);
        chk("hold_pc", pc, 32'h10);
        cyc(); cyc(); cyc();
        chk("hold_valid", {31'b0, ifid_valid}, 32'h0);
        stall = 1'b0;
        cyc();
        chk("release_valid", {31'b0, ifid_valid}, 32'h1);
        chk("release_ifid_pc", ifid_pc, 32'h10);
        chk("release_instr", ifid_instr, 32'h10 ^ c_key);
        chk("release_addr", imem_addr, 32'h14);

        // ---------------- redirect while a request is unanswered ----------------
        mem_off = 1'b1;
        cyc();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        cyc();
        redirect = 1'b0;
        chk("drain_req", {31'b0, imem_req}, 32'h1);
        chk("drain_addr_old", imem_addr, 32'h18);
        chk("drain_pc", pc, 32'h100);
        chk("drain_valid", {31'b0, ifid_valid}, 32'h0);
        cyc();
        mem_off = 1'b0;
        lat_cnt = 0;
        cyc();
        cyc();
        chk("after_drain_addr", imem_addr, 32'h100);
        chk("after_drain_valid", {31'b0, ifid_valid}, 32'h0);

        // ---------------- redirect + ack + stall in one cycle ----------------
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        cyc();
        stall = 1'b0; redirect = 1'b0;
        chk("rda_valid", {31'b0, ifid_valid}, 32'h0);
        chk("rda_addr", imem_addr, 32'h200);
        chk("rda_req", {31'b0, imem_req}, 32'h1);

        // ---------------- PC wrap, then reset mid-request ----------------
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        cyc();
        redirect = 1'b0;
        cyc();
        chk("wrap_ifid_pc", ifid_pc, 32'hFFFF_FFFC);
        chk("wrap_ifid_pc4", ifid_pc4, 32'h0);
        chk("wrap_instr", ifid_instr, 32'h5A5A_FFFC);
        chk("wrap_pc", pc, 32'h0);
        mem_off = 1'b1;
        cyc();
        chk("mid_req", {31'b0, imem_req}, 32'h1);
        rst = 1'b1;
        cyc();
        chk("midrst_req", {31'b0, imem_req}, 32'h0);
        chk("midrst_pc", pc, 32'h0);
        chk("midrst_valid", {31'b0, ifid_valid}, 32'h0);
        chk("midrst_ifid_pc", ifid_pc, 32'h0);
        chk("midrst_ifid_pc4", ifid_pc4, 32'h0);
        chk("midrst_instr", ifid_instr, 32'h0);
        rst = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        cyc();
        chk("late_ack_req", {31'b0, imem_req}, 32'h1);
        chk("late_ack_addr", imem_addr, 32'h0);
        chk("late_ack_valid", {31'b0, ifid_valid}, 32'h0);

        // ---------------- randomized traffic ----------------
        mem_off = 1'b0;
        lat_set = -1;
        lat_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            stall    = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 15) == 0);
            case ($urandom_range(0, 3))
                0:       redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                1:       redirect_pc = $urandom;
                default: redirect_pc = $urandom & 32'h0000_0FFF;
            endcase
            rst = ($urandom_range(0, 499) == 0);
        end
        rst = 1'b0; stall = 1'b0; redirect = 1'b0;
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_if_fetch_ctrl
`default_nettype wire
